// File: rtl/key_expand_writer_if.sv
// Handshake and key-memory write bus for key_expand_writer.
// KEYEXP_HOLD_EN adds the hold input.
interface key_expand_writer_if;
  logic         start;
`ifdef KEYEXP_HOLD_EN
  logic         hold;
`endif
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         key_we;
  logic [3:0]   key_index;
  logic [127:0] key_data;

`ifdef KEYEXP_HOLD_EN
  modport master (
    input  start, hold, key_in,
    output busy, done, key_we, key_index, key_data
  );
  modport slave (
    output start, hold, key_in,
    input  busy, done, key_we, key_index, key_data
  );
`else
  modport master (
    input  start, key_in,
    output busy, done, key_we, key_index, key_data
  );
  modport slave (
    output start, key_in,
    input  busy, done, key_we, key_index, key_data
  );
`endif
endinterface

// File: rtl/key_expand_writer.sv
// AES-128 key schedule; writes round keys 1..NUM_ROUNDS to the key memory
// at indices 0..NUM_ROUNDS-1, one shared S-box, 5 cycles per round key.
// Optional macro KEYEXP_HOLD_EN adds a hold input that stalls expansion.
module key_expand_writer #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic                clk,
  input  logic                rst,
  key_expand_writer_if.master kif
);

  typedef enum logic [1:0] {IDLE, SUB, WRITE, DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t       state_q;
  logic [1:0]   byte_q;
  logic [3:0]   round_q;
  logic [31:0]  temp_q;
  logic [127:0] wkey_q;
  logic         busy_q;
  logic         done_q;
  logic         key_we_q;
  logic [3:0]   key_index_q;
  logic [127:0] key_data_q;

  logic         hold_w;
  logic [31:0]  rot_w;
  logic [7:0]   sbox_in;
  logic [7:0]   sbox_out;
  logic [31:0]  temp_d;
  logic [31:0]  t_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] wkey_d;

`ifdef KEYEXP_HOLD_EN
  assign hold_w = kif.hold;
`else
  assign hold_w = 1'b0;
`endif

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // S-box byte of RotWord(w3) for the current byte slot, and the next round key
  // built from the temp word as it will stand once this byte is stored.
  always_comb begin
    rot_w  = {wkey_q[23:0], wkey_q[31:24]};
    temp_d = temp_q;
    case (byte_q)
      2'd0:    sbox_in = rot_w[31:24];
      2'd1:    sbox_in = rot_w[23:16];
      2'd2:    sbox_in = rot_w[15:8];
      default: sbox_in = rot_w[7:0];
    endcase
    sbox_out = SBOX[{~sbox_in, 3'b111} -: 8];
    case (byte_q)
      2'd0:    temp_d[31:24] = sbox_out;
      2'd1:    temp_d[23:16] = sbox_out;
      2'd2:    temp_d[15:8]  = sbox_out;
      default: temp_d[7:0]   = sbox_out;
    endcase
    t_w    = temp_d ^ {rcon(round_q), 24'h0};
    n0     = wkey_q[127:96] ^ t_w;
    n1     = wkey_q[95:64]  ^ n0;
    n2     = wkey_q[63:32]  ^ n1;
    n3     = wkey_q[31:0]   ^ n2;
    wkey_d = {n0, n1, n2, n3};
  end

  // Control FSM with registered outputs.
  // The round key is computed on the last SUB edge so that key_we/key_index/
  // key_data are already registered throughout the WRITE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_q      <= '0;
      round_q     <= '0;
      temp_q      <= '0;
      wkey_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_we_q    <= 1'b0;
      key_index_q <= '0;
      key_data_q  <= '0;
    end else if (!(hold_w && (state_q == SUB || state_q == WRITE))) begin
      case (state_q)
        IDLE: begin
          if (kif.start) begin
            wkey_q  <= kif.key_in;
            round_q <= '0;
            byte_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SUB;
          end
        end
        SUB: begin
          temp_q <= temp_d;
          byte_q <= byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            key_we_q    <= 1'b1;
            key_index_q <= round_q;
            key_data_q  <= wkey_d;
            wkey_q      <= wkey_d;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          key_we_q <= 1'b0;
          if (round_q == LAST_ROUND) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
            byte_q  <= '0;
            state_q <= SUB;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign kif.busy      = busy_q;
  assign kif.done      = done_q;
  assign kif.key_we    = key_we_q & ~hold_w;
  assign kif.key_index = key_index_q;
  assign kif.key_data  = key_data_q;

endmodule

// File: tb/tb_key_expand_writer.sv
module tb_key_expand_writer;

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic clk = 1'b0;
  logic rst_r;
  logic start_r;
  logic sel;
  logic [127:0] key_r;
`ifdef KEYEXP_HOLD_EN
  logic hold_r;
`endif

  always #5 clk = ~clk;

  key_expand_writer_if kif ();
  key_expand_writer_if kif4 ();

  assign kif.start   = start_r & ~sel;
  assign kif4.start  = start_r & sel;
  assign kif.key_in  = key_r;
  assign kif4.key_in = key_r;
`ifdef KEYEXP_HOLD_EN
  assign kif.hold  = hold_r & ~sel;
  assign kif4.hold = hold_r & sel;
`endif

  key_expand_writer #(.NUM_ROUNDS(10)) dut (
    .clk (clk),
    .rst (rst_r),
    .kif (kif)
  );

  key_expand_writer #(.NUM_ROUNDS(4)) dut4 (
    .clk (clk),
    .rst (rst_r),
    .kif (kif4)
  );

  logic         obs_we, obs_busy, obs_done;
  logic [3:0]   obs_idx;
  logic [127:0] obs_data;
  assign obs_we   = sel ? kif4.key_we    : kif.key_we;
  assign obs_busy = sel ? kif4.busy      : kif.busy;
  assign obs_done = sel ? kif4.done      : kif.done;
  assign obs_idx  = sel ? kif4.key_index : kif.key_index;
  assign obs_data = sel ? kif4.key_data  : kif.key_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] cap [0:15];
  logic [3:0]   last_idx [0:1];
  logic [127:0] last_data [0:1];

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] expect_data;
  } vec_t;
  vec_t vecs [0:4];

  task automatic chk(input string name, input int cyc, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference AES arithmetic: GF(2^8) multiply, inverse, affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    if (a == 8'h00) inv = 8'h00;
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Textbook FIPS-197 expansion into 44 words; returns round key r.
  function automatic logic [127:0] model_rk(input logic [127:0] key, input int r);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // One expansion on the selected DUT, checked cycle by cycle.
  // rep0/rep1: cycles with a spurious start; rc: reset cycle; h0/hlen: hold window.
  task automatic run_exp(input logic [127:0] key, input int nr, input int rep0, input int rep1,
                         input int rc, input int h0, input int hlen);
    logic [127:0] exp_rk [0:10];
    int  shift, limit, nwe, exp_cnt, tr, exp_r, s;
    bit  exp_we, aborted;
    s = sel ? 1 : 0;
    for (int r = 1; r <= nr; r++) exp_rk[r] = model_rk(key, r);
    for (int i = 0; i < 16; i++) cap[i] = '0;
    shift = (h0 > 0) ? hlen : 0;
    limit = 5*nr + shift + 4;
    nwe = 0;
    exp_cnt = 0;
    @(negedge clk);
    key_r   = key;
    start_r = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= limit; c++) begin
      if (c > 1) @(posedge clk);
      #1;
      start_r = (c == rep0 || c == rep1);
      rst_r   = (c == rc);
`ifdef KEYEXP_HOLD_EN
      hold_r  = (c >= h0 && c < h0 + hlen);
`endif
      key_r   = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      aborted = (rc > 0 && c > rc);
      if (aborted && c == rc + 1) begin
        last_idx[0] = '0; last_data[0] = '0;
        last_idx[1] = '0; last_data[1] = '0;
      end
      exp_we = 1'b0;
      exp_r  = 0;
      for (int r = 0; r < nr; r++) begin
        tr = 5*(r+1) + ((h0 > 0 && 5*(r+1) >= h0) ? hlen : 0);
        if (tr == c) begin exp_we = 1'b1; exp_r = r; end
      end
      if (aborted) exp_we = 1'b0;
      if (exp_we) exp_cnt++;
      if (obs_we) nwe++;
      chk("key_we", c, {127'd0, obs_we}, {127'd0, exp_we});
      chk("busy", c, {127'd0, obs_busy}, {127'd0, (!aborted && c <= 5*nr + shift)});
      chk("done", c, {127'd0, obs_done}, {127'd0, (!aborted && c == 5*nr + shift + 1)});
      if (exp_we) begin
        chk("key_index", c, {124'd0, obs_idx}, 128'(exp_r));
        chk("key_data", c, obs_data, exp_rk[exp_r + 1]);
        last_idx[s]  = 4'(exp_r);
        last_data[s] = exp_rk[exp_r + 1];
        cap[obs_idx] = obs_data;
      end else begin
        chk("index_hold", c, {124'd0, obs_idx}, {124'd0, last_idx[s]});
        chk("data_hold", c, obs_data, last_data[s]);
      end
    end
    chk("strobe_count", limit, 128'(nwe), 128'(exp_cnt));
    start_r = 1'b0;
    rst_r   = 1'b0;
`ifdef KEYEXP_HOLD_EN
    hold_r  = 1'b0;
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] rkey;
    int rsel, rrep;
    vecs[0] = '{KEY_A1, 0, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[1] = '{KEY_A1, 1, 128'hf2c295f27a96b9435935807a7359f67f};
    vecs[2] = '{KEY_A1, 9, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[3] = '{128'h0, 0, 128'h62636363626363636263636362636363};
    vecs[4] = '{128'h0, 9, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    last_idx[0] = '0; last_data[0] = '0;
    last_idx[1] = '0; last_data[1] = '0;

    sel     = 1'b0;
    start_r = 1'b1;
    rst_r   = 1'b1;
    key_r   = KEY_A1;
`ifdef KEYEXP_HOLD_EN
    hold_r  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 0, {127'd0, kif.key_we}, 128'd0);
    chk("rst_busy", 0, {127'd0, kif.busy}, 128'd0);
    chk("rst_done", 0, {127'd0, kif.done}, 128'd0);
    chk("rst_index", 0, {124'd0, kif.key_index}, 128'd0);
    chk("rst_data", 0, kif.key_data, 128'd0);
    chk("rst_busy4", 0, {127'd0, kif4.busy}, 128'd0);
    start_r = 1'b0;
    rst_r   = 1'b0;

    // Known-answer table against FIPS-197 vectors.
    for (int i = 0; i < 5; i++) begin
      run_exp(vecs[i].key, 10, 0, 0, 0, 0, 0);
      chk("kat", i, cap[vecs[i].idx], vecs[i].expect_data);
    end

    // Spurious start pulses during expansion are ignored.
    run_exp(KEY_A1, 10, 3, 20, 0, 0, 0);
    chk("repulse_idx9", 0, cap[9], vecs[2].expect_data);

    // Reset after four writes aborts; a fresh start then runs clean.
    run_exp(KEY_A1, 10, 0, 0, 23, 0, 0);
    run_exp(KEY_A1, 10, 0, 0, 0, 0, 0);
    chk("after_rst_idx0", 0, cap[0], vecs[0].expect_data);

    // Four-round instance.
    sel = 1'b1;
    run_exp(KEY_A1, 4, 0, 0, 0, 0, 0);
    chk("nr4_idx3", 0, cap[3], 128'hef44a541a8525b7fb671253bdb0bad00);
    sel = 1'b0;

`ifdef KEYEXP_HOLD_EN
    // Hold over cycles 9..12 delays the index-1 write to cycle 14.
    run_exp(KEY_A1, 10, 0, 0, 0, 9, 4);
    chk("hold_idx1", 0, cap[1], vecs[1].expect_data);
`endif

    // Random keys on both instances against the reference model.
    for (int i = 0; i < 6; i++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      rsel = $urandom_range(0, 1);
      sel  = rsel[0];
      rrep = $urandom_range(1, sel ? 20 : 50);
      run_exp(rkey, sel ? 4 : 10, rrep, 0, 0, 0, 0);
    end
    sel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
